// File: rtl/zet_pic_pkg.sv
// Shared definitions for the wb_pic8259 interrupt controller.
//  - OCW command encodings written to port 0x20
//  - irq_num_t : 3-bit interrupt line number
//  - irq_onehot: converts an interrupt number to its 8-bit mask
package zet_pic_pkg;

   localparam logic [7:0] OCW_NS_EOI = 8'h20;     // non-specific EOI
   localparam logic [4:0] OCW_SEOI   = 5'b01100;  // specific EOI, low 3 bits = level
   localparam logic [7:0] OCW_RD_IRR = 8'h0A;     // select IRR for reads
   localparam logic [7:0] OCW_RD_ISR = 8'h0B;     // select ISR for reads

   typedef logic [2:0] irq_num_t;

   function automatic logic [7:0] irq_onehot(input irq_num_t n);
      return 8'b0000_0001 << n;
   endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Fixed-priority encoder for eight interrupt lines; bit 0 has the highest
// priority.
// Ports:
//  req   in  8  request vector
//  valid out 1  at least one request bit is set
//  idx   out 3  number of the highest-priority set bit (0 when none)
module pic_prio_enc
   import zet_pic_pkg::*;
(
   input  logic [7:0] req,
   output logic       valid,
   output irq_num_t   idx
);

   // Lowest set bit wins.
   always_comb begin
      valid = 1'b1;
      idx   = 3'd0;
      casez (req)
         8'b???????1: idx = 3'd0;
         8'b??????10: idx = 3'd1;
         8'b?????100: idx = 3'd2;
         8'b????1000: idx = 3'd3;
         8'b???10000: idx = 3'd4;
         8'b??100000: idx = 3'd5;
         8'b?1000000: idx = 3'd6;
         8'b10000000: idx = 3'd7;
         default: begin
            valid = 1'b0;
            idx   = 3'd0;
         end
      endcase
   end

endmodule

// File: rtl/wb_pic8259.sv
// PC-style 8-input interrupt controller, Wishbone I/O slave at ports 0x20/0x21.
// Port 0x20 (byte lane 0): OCW commands (EOI, IRR/ISR read select), reads IRR or ISR.
// Port 0x21 (byte lane 1): interrupt mask register.
// Ports:
//  wb_clk_i  in   1  clock
//  wb_rst_i  in   1  synchronous active-high reset
//  wb_dat_i  in  16  write data, [7:0]=0x20, [15:8]=0x21
//  wb_dat_o  out 16  registered read data, unselected lanes read 0
//  wb_sel_i  in   2  byte selects
//  wb_we_i   in   1  write enable
//  wb_stb_i  in   1  decoded strobe
//  wb_ack_o  out  1  single-cycle registered acknowledge
//  irq_i     in   8  rising-edge interrupt requests, IRQ0 highest priority
//  inta_i    in   1  CPU interrupt acknowledge (level)
//  intr_o    out  1  registered interrupt request to the CPU
//  vec_o     out  8  vector presented during acknowledge
// Configuration macro: PIC_AUTO_EOI_EN -- when defined, acknowledge does not
// set ISR and nesting is disabled (intr_o follows the unmasked request).
module wb_pic8259
   import zet_pic_pkg::*;
#(
   parameter logic [7:0] VEC_BASE  = 8'h08,
   parameter logic [7:0] RESET_IMR = 8'h00
)(
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [15:0] wb_dat_i,
   output logic [15:0] wb_dat_o,
   input  logic [1:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_stb_i,
   output logic        wb_ack_o,
   input  logic [7:0]  irq_i,
   input  logic        inta_i,
   output logic        intr_o,
   output logic [7:0]  vec_o
);

   logic [7:0]  irr_r, isr_r, imr_r, irq_q_r;
   logic        inta_q_r, rd_isr_r;

   logic        p_valid_s, s_valid_s;
   irq_num_t    p_idx_s, s_idx_s;

   logic        acc_s, wr_cmd_s, wr_imr_s, ack_first_s;
   logic [7:0]  ack_clr_s, ack_set_s, eoi_clr_s;
   logic [7:0]  vec_nxt_s;
   logic        intr_nxt_s, rd_isr_nxt_s;
   logic [15:0] dat_nxt_s;

   pic_prio_enc u_pend_enc (
      .req   (irr_r & ~imr_r),
      .valid (p_valid_s),
      .idx   (p_idx_s)
   );

   pic_prio_enc u_serv_enc (
      .req   (isr_r),
      .valid (s_valid_s),
      .idx   (s_idx_s)
   );

   assign acc_s       = wb_stb_i & ~wb_ack_o;
   assign wr_cmd_s    = acc_s & wb_we_i & wb_sel_i[0];
   assign wr_imr_s    = acc_s & wb_we_i & wb_sel_i[1];
   assign ack_first_s = inta_i & ~inta_q_r;

   // Acknowledge decode: which IRR bit to retire, which ISR bit to set, next vector.
   always_comb begin
      ack_clr_s = 8'h00;
      ack_set_s = 8'h00;
      vec_nxt_s = vec_o;
      if (ack_first_s) begin
         if (p_valid_s) begin
            ack_clr_s = irq_onehot(p_idx_s);
`ifndef PIC_AUTO_EOI_EN
            ack_set_s = irq_onehot(p_idx_s);
`endif
            vec_nxt_s = VEC_BASE | {5'b00000, p_idx_s};
         end else begin
            vec_nxt_s = VEC_BASE | 8'h07;   // spurious acknowledge
         end
      end else begin
         vec_nxt_s = vec_o;
      end
   end

   // OCW decode on port 0x20; EOI works from the ISR value before this cycle's acknowledge.
   always_comb begin
      eoi_clr_s    = 8'h00;
      rd_isr_nxt_s = rd_isr_r;
      if (wr_cmd_s) begin
         if (wb_dat_i[7:0] == OCW_NS_EOI) begin
            eoi_clr_s = s_valid_s ? irq_onehot(s_idx_s) : 8'h00;
         end else if (wb_dat_i[7:3] == OCW_SEOI) begin
            eoi_clr_s = irq_onehot(wb_dat_i[2:0]);
         end else if (wb_dat_i[7:0] == OCW_RD_IRR) begin
            rd_isr_nxt_s = 1'b0;
         end else if (wb_dat_i[7:0] == OCW_RD_ISR) begin
            rd_isr_nxt_s = 1'b1;
         end else begin
            eoi_clr_s = 8'h00;
         end
      end else begin
         rd_isr_nxt_s = rd_isr_r;
      end
   end

   // Interrupt request: suppressed during acknowledge, nested unless auto-EOI.
   always_comb begin
      intr_nxt_s = 1'b0;
`ifdef PIC_AUTO_EOI_EN
      intr_nxt_s = ~inta_i & p_valid_s;
`else
      intr_nxt_s = ~inta_i & p_valid_s & (~s_valid_s | (p_idx_s < s_idx_s));
`endif
   end

   // Read data captured on the accepted bus cycle, held otherwise.
   always_comb begin
      dat_nxt_s = wb_dat_o;
      if (acc_s) begin
         dat_nxt_s[15:8] = wb_sel_i[1] ? imr_r : 8'h00;
         dat_nxt_s[7:0]  = wb_sel_i[0] ? (rd_isr_r ? isr_r : irr_r) : 8'h00;
      end else begin
         dat_nxt_s = wb_dat_o;
      end
   end

   // State registers; an edge on a line re-arms IRR even if it is being acknowledged.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wb_ack_o <= 1'b0;
         wb_dat_o <= 16'h0000;
         intr_o   <= 1'b0;
         vec_o    <= 8'h00;
         irr_r    <= 8'h00;
         isr_r    <= 8'h00;
         imr_r    <= RESET_IMR;
         rd_isr_r <= 1'b0;
         irq_q_r  <= irq_i;
         inta_q_r <= 1'b0;
      end else begin
         wb_ack_o <= acc_s;
         wb_dat_o <= dat_nxt_s;
         intr_o   <= intr_nxt_s;
         vec_o    <= vec_nxt_s;
         irr_r    <= (irr_r & ~ack_clr_s) | (irq_i & ~irq_q_r);
         isr_r    <= (isr_r & ~eoi_clr_s) | ack_set_s;
         imr_r    <= wr_imr_s ? wb_dat_i[15:8] : imr_r;
         rd_isr_r <= rd_isr_nxt_s;
         irq_q_r  <= irq_i;
         inta_q_r <= inta_i;
      end
   end

endmodule

// File: tb/tb_wb_pic8259.sv
// Directed self-checking bench for wb_pic8259 (default parameters).
// Expectations that differ under PIC_AUTO_EOI_EN are selected via AUTO.
module tb_wb_pic8259;

`ifdef PIC_AUTO_EOI_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] dat_i;
   logic [15:0] dat_o;
   logic [1:0]  sel;
   logic        we, stb, ack;
   logic [7:0]  irq;
   logic        inta, intr;
   logic [7:0]  vec;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   wb_pic8259 dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wb_dat_i (dat_i),
      .wb_dat_o (dat_o),
      .wb_sel_i (sel),
      .wb_we_i  (we),
      .wb_stb_i (stb),
      .wb_ack_o (ack),
      .irq_i    (irq),
      .inta_i   (inta),
      .intr_o   (intr),
      .vec_o    (vec)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] isr_exp(input logic [7:0] v);
      return AUTO ? 8'h00 : v;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // All tasks start and end on a falling edge; each access leaves one idle cycle.
   task automatic bus_wr(input logic [1:0] s, input logic [15:0] d);
      stb = 1'b1; we = 1'b1; sel = s; dat_i = d;
      @(negedge clk);
      stb = 1'b0; we = 1'b0;
      @(negedge clk);
   endtask

   task automatic bus_rd(input logic [1:0] s, output logic [15:0] d);
      stb = 1'b1; we = 1'b0; sel = s;
      @(negedge clk);
      d = dat_o;
      stb = 1'b0;
      @(negedge clk);
   endtask

   task automatic rd_lo(input bit want_isr, output logic [15:0] d);
      bus_wr(2'b01, {8'h00, (want_isr ? 8'h0B : 8'h0A)});
      bus_rd(2'b01, d);
   endtask

   task automatic pulse(input logic [7:0] m);
      irq = m;
      @(negedge clk);
      irq = 8'h00;
   endtask

   task automatic do_ack();
      inta = 1'b1;
      tick(2);
      inta = 1'b0;
      tick(1);
   endtask

   logic [15:0] d;

   initial begin
      rst = 1'b1; dat_i = 16'h0000; sel = 2'b00; we = 1'b0; stb = 1'b0;
      irq = 8'h04; inta = 1'b0;       // IRQ2 held high through reset: no edge
      tick(3);
      rst = 1'b0;
      tick(1);
      check("rst_intr", {15'd0, intr}, 16'h0000);
      check("rst_vec",  {8'h00, vec}, 16'h0000);
      check("rst_ack",  {15'd0, ack}, 16'h0000);
      check("rst_dat",  dat_o, 16'h0000);
      irq = 8'h00;
      bus_rd(2'b11, d);
      check("rst_imr_irr", d, 16'h0000);

      // 1: IRQ0 request and acknowledge
      pulse(8'h01);
      check("t1_intr_early", {15'd0, intr}, 16'h0000);
      tick(1);
      check("t1_intr", {15'd0, intr}, 16'h0001);
      inta = 1'b1;
      tick(1);
      check("t1_intr_inta", {15'd0, intr}, 16'h0000);
      check("t1_vec", {8'h00, vec}, 16'h0008);
      tick(1);
      inta = 1'b0;
      tick(1);
      check("t1_intr_after", {15'd0, intr}, 16'h0000);
      check("t1_vec_hold", {8'h00, vec}, 16'h0008);
      rd_lo(1'b1, d);
      check("t1_isr", d, {8'h00, isr_exp(8'h01)});
      rd_lo(1'b0, d);
      check("t1_irr", d, 16'h0000);

      // 2: nesting IRQ0 over IRQ1, IRQ3 held off until two EOIs
      bus_wr(2'b01, 16'h0020);
      pulse(8'h02);
      tick(1);
      check("t2_irq1_intr", {15'd0, intr}, 16'h0001);
      do_ack();
      check("t2_vec1", {8'h00, vec}, 16'h0009);
      pulse(8'h09);
      tick(1);
      check("t2_nest_intr", {15'd0, intr}, 16'h0001);
      do_ack();
      check("t2_vec0", {8'h00, vec}, 16'h0008);
      check("t2_held0", {15'd0, intr}, {15'd0, AUTO});
      bus_wr(2'b01, 16'h0020);
      check("t2_held1", {15'd0, intr}, {15'd0, AUTO});
      bus_wr(2'b01, 16'h0020);
      check("t2_release", {15'd0, intr}, 16'h0001);
      do_ack();
      check("t2_vec3", {8'h00, vec}, 16'h000B);
      bus_wr(2'b01, 16'h0020);
      rd_lo(1'b1, d);
      check("t2_isr_empty", d, 16'h0000);

      // 3: fully masked request still latches in IRR
      bus_wr(2'b10, 16'hFF00);
      pulse(8'h10);
      tick(2);
      check("t3_masked_intr", {15'd0, intr}, 16'h0000);
      rd_lo(1'b0, d);
      check("t3_irr", d, 16'h0010);
      bus_rd(2'b11, d);
      check("t3_both_lanes", d, 16'hFF10);

      // 4: spurious acknowledge
      inta = 1'b1;
      tick(1);
      check("t4_vec_spur", {8'h00, vec}, 16'h000F);
      tick(1);
      inta = 1'b0;
      tick(1);
      rd_lo(1'b1, d);
      check("t4_isr", d, 16'h0000);
      rd_lo(1'b0, d);
      check("t4_irr", d, 16'h0010);

      // 5: specific EOI and ack timing
      bus_wr(2'b10, 16'h0000);
      check("t5_unmask_intr", {15'd0, intr}, 16'h0001);
      do_ack();
      check("t5_vec4", {8'h00, vec}, 16'h000C);
      bus_wr(2'b01, 16'h0064);
      pulse(8'h08);
      tick(1);
      do_ack();
      check("t5_vec3", {8'h00, vec}, 16'h000B);
      pulse(8'h02);
      tick(1);
      check("t5_irq1_intr", {15'd0, intr}, 16'h0001);
      do_ack();
      check("t5_vec1", {8'h00, vec}, 16'h0009);
      rd_lo(1'b1, d);
      check("t5_isr_0a", d, {8'h00, isr_exp(8'h0A)});
      bus_wr(2'b01, 16'h0063);
      rd_lo(1'b1, d);
      check("t5_isr_02", d, {8'h00, isr_exp(8'h02)});
      check("t5_ack_idle", {15'd0, ack}, 16'h0000);
      stb = 1'b1; we = 1'b0; sel = 2'b01;
      tick(1);
      check("t5_ack_1cyc", {15'd0, ack}, 16'h0001);
      check("t5_rd_dat", dat_o, {8'h00, isr_exp(8'h02)});
      tick(1);
      check("t5_ack_pulse", {15'd0, ack}, 16'h0000);
      stb = 1'b0;
      tick(1);
      bus_wr(2'b01, 16'h0020);

      // Edge on a line in the same cycle its IRR bit is acknowledged: set wins
      pulse(8'h04);
      tick(1);
      inta = 1'b1; irq = 8'h04;
      tick(1);
      irq = 8'h00;
      check("e_vec2", {8'h00, vec}, 16'h000A);
      tick(1);
      inta = 1'b0;
      tick(1);
      check("e_intr_same", {15'd0, intr}, {15'd0, AUTO});
      rd_lo(1'b0, d);
      check("e_irr_rearm", d, 16'h0004);
      bus_wr(2'b01, 16'h0020);
      check("e_intr_eoi", {15'd0, intr}, 16'h0001);
      do_ack();
      bus_wr(2'b01, 16'h0020);
      rd_lo(1'b0, d);
      check("e_irr_clear", d, 16'h0000);

      // 6: reset during acknowledge
      bus_wr(2'b10, 16'h5A00);
      pulse(8'h01);
      tick(1);
      check("t6_intr", {15'd0, intr}, 16'h0001);
      inta = 1'b1;
      tick(1);
      check("t6_vec", {8'h00, vec}, 16'h0008);
      rst = 1'b1;
      tick(1);
      check("t6_rst_intr", {15'd0, intr}, 16'h0000);
      check("t6_rst_vec", {8'h00, vec}, 16'h0000);
      check("t6_rst_dat", dat_o, 16'h0000);
      rst = 1'b0; inta = 1'b0;
      tick(1);
      rd_lo(1'b1, d);
      check("t6_isr", d, 16'h0000);
      bus_rd(2'b10, d);
      check("t6_imr", d, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
